// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared types and constants for the single-port RAM arbiter
package spram_arb_pkg;

    localparam int NUM_REQ           = 2;
    localparam int RAM_WIDTH_DEF     = 32;
    localparam int RAM_ADDR_BITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic                         we;
        logic [RAM_ADDR_BITS_DEF-1:0] addr;
        logic [RAM_WIDTH_DEF-1:0]     wdata;
    } req_t;

endpackage

// File: rtl/spram_arbiter_rr_pick2.sv
// rtl/spram_arbiter_rr_pick2.sv - two-way round-robin pick producing a one-hot grant
module rr_pick2
    import spram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    // a lone requester always wins; the pointer only breaks ties
    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester round-robin arbiter with lock for one shared single-port RAM
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int LOCK_MAX      = 16
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ-1:0]                      req_we,
    input  logic [NUM_REQ-1:0]                      req_lock,
    input  logic [NUM_REQ-1:0][RAM_ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][RAM_WIDTH-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    output logic [RAM_WIDTH-1:0]                    rsp_rdata,
    output logic                                    ram_we,
    output logic [RAM_ADDR_BITS-1:0]                ram_addr,
    output logic [RAM_WIDTH-1:0]                    ram_wdata,
    input  logic [RAM_WIDTH-1:0]                    ram_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    // the grant that opens a lock plus lock_cnt in-lock grants; release on the LOCK_MAX-th in total
    localparam int LIMIT = (LOCK_MAX > 1) ? LOCK_MAX - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t                   state, state_nxt;
    logic                     rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]         lock_cnt, lock_cnt_nxt;
    logic [NUM_REQ-1:0]       pick_grant;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       rsp_q;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic [RAM_WIDTH-1:0]     wdata_q;
    logic                     xfer;
    logic                     win;
    logic                     owner;

    rr_pick2 u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant)
    );

    // grant: round-robin when unlocked, only the owner (if valid) when locked, nothing in reset
    always_comb begin
        grant = '0;
        if (rstn) begin
            case (state)
                IDLE:    grant = pick_grant;
                LOCK0:   grant = {1'b0, req_valid[0]};
                LOCK1:   grant = {req_valid[1], 1'b0};
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign win       = grant[1];
    assign owner     = (state == LOCK1);

    assign ram_we    = xfer & req_we[win];
    assign ram_addr  = xfer ? req_addr[win]  : addr_q;
    assign ram_wdata = xfer ? req_wdata[win] : wdata_q;

    assign rsp_valid = rsp_q;
    assign rsp_rdata = (|rsp_q) ? ram_rdata : '0;

    // lock state, round-robin pointer and lock counter next values
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_cnt_nxt = lock_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (req_lock[win] && (LOCK_MAX > 1)) begin
                        state_nxt    = win ? LOCK1 : LOCK0;
                        lock_cnt_nxt = '0;
                    end else begin
                        rr_ptr_nxt = ~win;
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (!req_valid[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = ~owner;
                end else begin
                    if (lock_cnt != CNT_SAT) begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                    if (!req_lock[owner] || (lock_cnt >= CNT_LIMIT)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = ~owner;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                rr_ptr_nxt = 1'b0;
            end
        endcase
    end

    // arbitration state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // hold last granted address/data and raise a response pulse the cycle after each read grant
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            if (xfer) begin
                addr_q  <= req_addr[win];
                wdata_q <= req_wdata[win];
            end
            rsp_q <= grant & ~req_we;
        end
    end

    a_onehot_grant: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
    a_no_write_idle: assert property (@(posedge clk) disable iff (!rstn) !(|req_ready) |-> !ram_we);
    a_rsp0_has_read: assert property (@(posedge clk) disable iff (!rstn)
        rsp_valid[0] |-> $past(req_ready[0] && req_valid[0] && !req_we[0]));
    a_rsp1_has_read: assert property (@(posedge clk) disable iff (!rstn)
        rsp_valid[1] |-> $past(req_ready[1] && req_valid[1] && !req_we[1]));

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - randomized and directed self-checking bench for spram_arbiter
module tb_spram_arbiter;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int LM = 16;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [1:0]          req_valid = '0;
    logic [1:0]          req_ready;
    logic [1:0]          req_we = '0;
    logic [1:0]          req_lock = '0;
    logic [1:0][AW-1:0]  req_addr = '0;
    logic [1:0][W-1:0]   req_wdata = '0;
    logic [1:0]          rsp_valid;
    logic [W-1:0]        rsp_rdata;
    logic                ram_we;
    logic [AW-1:0]       ram_addr;
    logic [W-1:0]        ram_wdata;
    logic [W-1:0]        ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW), .LOCK_MAX(LM)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // single-port RAM with registered read
    logic [W-1:0] ram_mem   [1024];
    logic [W-1:0] model_mem [1024];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= ram_mem[ram_addr];
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i]   = 32'h0100_0193 * i + 32'h55;
            model_mem[i] = 32'h0100_0193 * i + 32'h55;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: lock owner (-1 = none), grants held in the lock, tie-break pointer
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_rr    = 0;
    int          m_w;
    logic [1:0]  m_g;
    logic [1:0]  m_rsp = '0;
    logic [W-1:0]  m_data = '0;
    logic [W-1:0]  m_last_wdata = '0;
    logic [AW-1:0] m_last_addr = '0;

    always begin
        @(negedge clk);
        #1;
        if (!rstn) begin
            chk("rst_outputs", {req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_wdata}, '0);
            m_owner = -1; m_held = 0; m_rr = 0; m_rsp = '0;
            m_last_addr = '0; m_last_wdata = '0;
        end else begin
            if (m_owner >= 0)             m_g = req_valid[m_owner] ? (2'b01 << m_owner) : 2'b00;
            else if (req_valid == 2'b11)  m_g = 2'b01 << m_rr;
            else                          m_g = req_valid;
            m_w = m_g[1] ? 1 : 0;

            chk("req_ready", req_ready, m_g);
            chk("rsp_valid", rsp_valid, m_rsp);
            chk("rsp_rdata", rsp_rdata, (m_rsp != 0) ? m_data : '0);
            if (m_g != 0) begin
                chk("ram_we", ram_we, req_we[m_w]);
                chk("ram_addr", ram_addr, req_addr[m_w]);
                chk("ram_wdata", ram_wdata, req_wdata[m_w]);
            end else begin
                chk("ram_we_idle", ram_we, 1'b0);
                chk("ram_addr_hold", ram_addr, m_last_addr);
                chk("ram_wdata_hold", ram_wdata, m_last_wdata);
            end

            m_rsp = '0;
            if (m_g != 0) begin
                m_last_addr  = req_addr[m_w];
                m_last_wdata = req_wdata[m_w];
                if (req_we[m_w]) begin
                    model_mem[req_addr[m_w]] = req_wdata[m_w];
                end else begin
                    m_rsp  = m_g;
                    m_data = model_mem[req_addr[m_w]];
                end
            end

            if (m_owner < 0) begin
                if (m_g != 0) begin
                    if (req_lock[m_w]) begin m_owner = m_w; m_held = 1; end
                    else m_rr = 1 - m_w;
                end
            end else if (!req_valid[m_owner]) begin
                m_rr = 1 - m_owner; m_owner = -1;
            end else begin
                m_held++;
                if (!req_lock[m_owner] || m_held >= LM) begin
                    m_rr = 1 - m_owner; m_owner = -1;
                end
            end
        end
    end

    task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
        @(negedge clk);
        rstn = 1'b1;
        req_valid = v; req_we = we; req_lock = lk;
        req_addr[0] = a0; req_addr[1] = a1;
        req_wdata[0] = d0; req_wdata[1] = d1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
    endtask

    int         run;
    logic       seen0;
    logic [1:0] prev;
    logic [1:0] lk_state;

    initial begin
        do_reset();

        // both requesters read continuously: grants alternate, first grant in release cycle
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 2'b00, 2'b00, AW'(k), AW'(k + 8), '0, '0);
            #2;
            chk("alt_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("alt_rsp", rsp_valid, prev);
            prev = req_ready;
        end
        cyc(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        #2 chk("alt_rsp_last", rsp_valid, 2'b10);

        // write then read the same address
        do_reset();
        cyc(2'b01, 2'b01, 2'b00, 10'h005, '0, 32'hDEADBEEF, '0);
        #2 chk("wr_grant", {req_ready, ram_we}, {2'b01, 1'b1});
        cyc(2'b01, 2'b00, 2'b00, 10'h005, '0, '0, '0);
        #2 chk("wr_no_rsp", rsp_valid, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        #2 chk("raw_data", {rsp_valid, rsp_rdata}, {2'b01, 32'hDEADBEEF});

        // requester 1 locked: LOCK_MAX consecutive grants, then requester 0
        do_reset();
        cyc(2'b01, 2'b00, 2'b00, 10'h001, '0, '0, '0);
        run = 0; seen0 = 1'b0;
        for (int k = 0; k < 24 && !seen0; k++) begin
            cyc(2'b11, 2'b00, 2'b10, 10'h002, 10'h003, '0, '0);
            #2;
            if (req_ready == 2'b10) run++;
            else if (req_ready == 2'b01) seen0 = 1'b1;
        end
        chk("lock_run", run, 16);
        chk("lock_then_req0", seen0, 1'b1);

        // lock dropped when owner goes invalid for one cycle
        do_reset();
        cyc(2'b11, 2'b00, 2'b01, 10'h004, 10'h006, '0, '0);
        #2 chk("lock0_open", req_ready, 2'b01);
        cyc(2'b10, 2'b00, 2'b01, 10'h004, 10'h006, '0, '0);
        #2 chk("lock0_gap", req_ready, 2'b00);
        cyc(2'b11, 2'b00, 2'b00, 10'h004, 10'h006, '0, '0);
        #2 chk("lock0_release", req_ready, 2'b10);

        // reset right after a read grant drops the response
        do_reset();
        cyc(2'b01, 2'b00, 2'b00, 10'h003, '0, '0, '0);
        #2 chk("rst_read_grant", req_ready, 2'b01);
        @(negedge clk);
        rstn = 1'b0;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        #2 chk("rst_mid", {req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_wdata}, '0);
        cyc(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        #2 chk("rst_release", {req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_wdata}, '0);
        cyc(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        #2 chk("rst_after", rsp_valid, 2'b00);

        // randomized traffic with sticky locks and occasional reset
        lk_state = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                rstn = 1'b0;
                req_valid = 2'($urandom);
            end else begin
                if ($urandom_range(0, 15) == 0) lk_state[0] = ~lk_state[0];
                if ($urandom_range(0, 15) == 0) lk_state[1] = ~lk_state[1];
                cyc({($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                    2'($urandom), lk_state,
                    AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                    $urandom, $urandom);
            end
        end

        @(negedge clk);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 32, meaning data width of the shared single-port RAM.
REQ-002 The block SHALL have parameter RAM_ADDR_BITS, default 10, meaning address width of the shared RAM.
REQ-003 The block SHALL have parameter LOCK_MAX, default 16, meaning the maximum number of consecutive grants one locked requester may hold.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rstn  in  1  asynchronous reset, active-low.
- req_valid  in  2  per-requester request valid; index 0 and 1.
- req_ready  out  2  per-requester grant; a request transfers when valid and ready are both high.
- req_we  in  2  per-requester write select (1 = write, 0 = read).
- req_lock  in  2  per-requester request to keep the grant on the next cycle.
- req_addr  in  2 x RAM_ADDR_BITS  per-requester address.
- req_wdata  in  2 x RAM_WIDTH  per-requester write data.
- rsp_valid  out  2  per-requester read-data valid pulse.
- rsp_rdata  out  RAM_WIDTH  read data, shared by both requesters and qualified by rsp_valid.
- ram_we  out  1  write enable to the RAM.
- ram_addr  out  RAM_ADDR_BITS  address to the RAM.
- ram_wdata  out  RAM_WIDTH  write data to the RAM.
- ram_rdata  in  RAM_WIDTH  registered read data from the RAM, valid one cycle after a non-write cycle.

Function
REQ-005 The block SHALL grant at most one requester per cycle; req_ready SHALL be one-hot or zero.
REQ-006 req_ready SHALL be combinational from req_valid and the arbitration state, with zero-cycle grant latency.
REQ-007 When both requesters are valid and none is locked, the grant SHALL go to the requester indicated by the round-robin pointer rr_ptr.
REQ-008 rr_ptr SHALL move to the requester not granted, after every unlocked transfer.
REQ-009 When exactly one requester is valid and none is locked, that requester SHALL be granted regardless of rr_ptr.
REQ-010 On a granted cycle, ram_we, ram_addr and ram_wdata SHALL equal the winner's req_we, req_addr and req_wdata, combinationally.
REQ-011 On a cycle with no grant, ram_we SHALL be 0, and ram_addr and ram_wdata SHALL hold their last granted values.
REQ-012 The block SHALL use the following states.
- IDLE: no lock active.
- LOCK0: requester 0 holds a lock.
- LOCK1: requester 1 holds a lock.
REQ-013 IDLE SHALL go to LOCKn on a transfer by requester n with req_lock[n]=1.
REQ-014 In LOCKn, requester n SHALL be the only requester eligible for grant, even if it is not valid.
REQ-015 LOCKn SHALL return to IDLE, and rr_ptr SHALL point to the other requester, on any of:
- a transfer with req_lock[n]=0;
- req_valid[n]=0 for one cycle;
- the lock counter reaching LOCK_MAX transfers.
REQ-016 The lock counter SHALL:
- be ceil(log2(LOCK_MAX+1)) bits wide;
- clear on entering LOCKn;
- increment per transfer;
- saturate, never wrap.
REQ-017 A read transfer by requester n in cycle T SHALL pulse rsp_valid[n] high for exactly cycle T+1, with rsp_rdata = ram_rdata.
REQ-018 rsp_valid SHALL never assert for write transfers; back-to-back reads SHALL yield back-to-back pulses in issue order.
REQ-019 A write followed by a read of the same address SHALL return the new data, because the RAM is strictly sequential.
REQ-020 rsp_rdata SHALL be 0 in any cycle where rsp_valid is 0.

Reset
REQ-021 While rstn=0, the block SHALL hold:
- req_ready=0, rsp_valid=0, rsp_rdata=0;
- ram_we=0, ram_addr=0, ram_wdata=0;
- state=IDLE, rr_ptr=0, lock counter=0.
REQ-022 Reset asserted mid-operation SHALL drop any pending response pulse and any active lock, with no rsp_valid after reset release.
REQ-023 The first grant after rstn rises SHALL be possible in the first clock edge's cycle.

Structure
REQ-024 Shared package spram_arb_pkg SHALL contain:
- the state enum (IDLE, LOCK0, LOCK1);
- NUM_REQ=2;
- a request struct typedef (we, addr, wdata) parameterised through package constants.
REQ-025 The round-robin pick logic SHALL be a sub-module rr_pick2 (inputs valid[1:0], ptr; output one-hot grant).
REQ-026 The block SHALL contain no RAM storage; it SHALL connect directly to one single-port RAM instance.

Verification
REQ-027 Both requesters read continuously, no lock, after reset -> grants alternate 0,1,0,1, and each rsp_valid arrives one cycle after its grant.
REQ-028 Requester 0 writes 0xDEADBEEF to address 0x005, then reads address 0x005 the next cycle -> rsp_valid[0] occurs two cycles after the write, with rsp_rdata=0xDEADBEEF.
REQ-029 Requester 1 holds req_lock=1 and req_valid=1 while requester 0 is valid -> requester 1 receives 16 consecutive grants, then requester 0 is granted.
REQ-030 Requester 0 asserts lock and then deasserts req_valid for one cycle while requester 1 is valid -> the state returns to IDLE, and requester 1 is granted the next cycle.
REQ-031 Reset is asserted in the cycle after a read grant -> no rsp_valid is seen, and all outputs are 0 during reset and in the first cycle after release if there are no requests.
REQ-032 An assertion SHALL check continuously that req_ready is one-hot0, that ram_we=0 whenever there is no grant, and that every rsp_valid has a matching read grant one cycle earlier.
